frame_buffer_arbiter: RTL and testbench
=======================================

// Module: frame_buffer_arbiter
// PURPOSE
//   Shares the single-port 320x240 RGB565 frame buffer RAM between three users:
//   - the VGA scan-out read port (highest priority, never stalled);
//   - a clear-screen sequencer;
//   - the drawing engine's write port, with a valid/ready handshake.
//   Sits between the RAM and both the VGA controller and the draw logic.
// PARAMETERS
//   ADDR_W       17       frame buffer address width
//   DATA_W       16       pixel width (RGB565)
//   FB_WIDTH     320      pixels per line
//   FB_HEIGHT    240      lines per frame
//   CLEAR_COLOR  16'h0000 pixel value written by the clear sequencer
// PORTS
//   clk          in   1       pixel clock (25 MHz); all logic on rising edge
//   rst          in   1       asynchronous reset, active-high
//   vga_req      in   1       VGA read request (tied to active_video)
//   vga_addr     in   ADDR_W  VGA read address
//   vga_data     out  DATA_W  read data = mem_rdata (RAM has 1-cycle read latency)
//   vga_rvalid   out  1       registered; high the cycle after a granted VGA read
//   wr_valid     in   1       draw engine write request
//   wr_ready     out  1       combinational; write accepted when wr_valid & wr_ready
//   wr_addr      in   ADDR_W  write address
//   wr_data      in   DATA_W  write pixel
//   clear_start  in   1       one-cycle pulse: start a full-screen clear
//   clear_busy   out  1       registered; high while the clear sequencer runs
//   clear_done   out  1       registered one-cycle pulse when the clear completes
//   mem_en       out  1       RAM enable
//   mem_we       out  1       RAM write enable
//   mem_addr     out  ADDR_W  RAM address
//   mem_wdata    out  DATA_W  RAM write data
//   mem_rdata    in   DATA_W  RAM read data (valid 1 cycle after a read)
// BEHAVIOUR
//   Reset values:
//   - Registered state: vga_rvalid=0, clear_busy=0, clear_done=0, clr_addr=0, state=IDLE.
//   - Combinational RAM outputs follow the rules below: mem_en=0, mem_we=0,
//     mem_addr=0, mem_wdata=0 whenever no grant is active (e.g. vga_req=0, wr_valid=0).
//   States:
//   - IDLE: clear_busy=0.
//   - CLEAR: clear_busy=1.
//   Grant is combinational, evaluated every cycle, priority VGA > CLEAR > WRITE:
//   - vga_req=1: mem_en=1, mem_we=0, mem_addr=vga_addr.
//     wr_ready=0; the clear sequencer holds.
//   - vga_req=0, state=CLEAR: mem_en=1, mem_we=1, mem_addr=clr_addr,
//     mem_wdata=CLEAR_COLOR. clr_addr increments. wr_ready=0.
//   - vga_req=0, state=IDLE: wr_ready=1.
//     If wr_valid=1: mem_en=1, mem_we=(wr_addr<FB_WIDTH*FB_HEIGHT),
//     mem_addr=wr_addr, mem_wdata=wr_data.
//     Out-of-range writes are accepted but dropped (mem_we=0).
//   - Otherwise: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   vga_rvalid <= vga_req (1-cycle latency, matching the RAM).
//   Transitions:
//   - IDLE -> CLEAR on clear_start (clr_addr<=0).
//     A write granted in the same cycle still completes.
//   - CLEAR -> IDLE after the clear write to FB_WIDTH*FB_HEIGHT-1 (76799).
//     clear_done pulses in the following cycle.
//   - clear_start while in CLEAR is ignored (no restart).
//   Clear progress:
//   - clr_addr advances only on cycles it owns the RAM.
//   - No address is skipped or repeated across vga_req pauses.
//   Reset mid-clear: immediate abort, state=IDLE, no clear_done pulse.
//   wr_valid may drop without acceptance; there is no internal write buffering.
// TESTING
//   1 Reset (rst=1, vga_req=0, wr_valid=0) -> clear_busy=0, clear_done=0,
//     vga_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ready=1.
//   2 vga_req=1, vga_addr=5, wr_valid=1 -> wr_ready=0, mem_addr=5, mem_we=0;
//     next cycle vga_rvalid=1, vga_data=mem_rdata.
//   3 vga_req=0, wr_valid=1, wr_addr=100, wr_data=16'hF800 -> same cycle
//     mem_we=1, mem_addr=100, mem_wdata=16'hF800, wr_ready=1.
//   4 clear_start with vga_req=0 -> exactly 76800 writes of CLEAR_COLOR,
//     addresses 0..76799 in order; clear_done pulses once; clear_busy falls.
//   5 Clear with vga_req toggling (320 cycles high, 480 low) -> clear pauses
//     whenever vga_req=1; RAM write log shows each address written exactly once.
//   6 wr_addr=76800 accepted with mem_we=0; rst asserted at clr_addr=1000
//     -> clear_busy=0 immediately and no clear_done pulse.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Arbitrates the single-port frame buffer RAM between VGA scan-out, the clear
// sequencer and the draw engine write port (priority VGA > CLEAR > WRITE).
//
// state   | meaning
// S_IDLE  | no clear running; draw engine writes granted when VGA is idle
// S_CLEAR | clear sequencer owns the RAM whenever VGA is idle
module frame_buffer_arbiter #(
  parameter int                 ADDR_W      = 17,
  parameter int                 DATA_W      = 16,
  parameter int                 FB_WIDTH    = 320,
  parameter int                 FB_HEIGHT   = 240,
  parameter logic [DATA_W-1:0]  CLEAR_COLOR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [DATA_W-1:0] vga_data_o,
  output logic              vga_rvalid_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clear_start_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W:0]   FB_SIZE   = (ADDR_W+1)'(FB_WIDTH * FB_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              vga_rvalid_q;
  logic              clear_done_q, clear_done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      clr_addr_q   <= '0;
      vga_rvalid_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      vga_rvalid_q <= vga_req_i;
      clear_done_q <= clear_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clear_done_d = 1'b0;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    wr_ready_o   = 1'b0;

    if (vga_req_i) begin
      mem_en_o   = 1'b1;
      mem_addr_o = vga_addr_i;
    end else if (state_q == S_CLEAR) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = clr_addr_q;
      mem_wdata_o = CLEAR_COLOR;
      if (clr_addr_q == LAST_ADDR) begin
        state_d      = S_IDLE;
        clr_addr_d   = '0;
        clear_done_d = 1'b1;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
    end else begin
      wr_ready_o = 1'b1;
      if (wr_valid_i) begin
        mem_en_o    = 1'b1;
        // out-of-range writes are handshaked but never reach the RAM
        mem_we_o    = ({1'b0, wr_addr_i} < FB_SIZE);
        mem_addr_o  = wr_addr_i;
        mem_wdata_o = wr_data_i;
      end
    end

    if (state_q == S_IDLE && clear_start_i) begin
      state_d    = S_CLEAR;
      clr_addr_d = '0;
    end
  end

  assign vga_data_o   = mem_rdata_i;
  assign vga_rvalid_o = vga_rvalid_q;
  assign clear_busy_o = (state_q == S_CLEAR);
  assign clear_done_o = clear_done_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: directed cases plus randomized
// traffic compared against a transaction-level model of the arbitration rules.
module tb_frame_buffer_arbiter;

  localparam int FB_PIXELS = 320 * 240;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req, vga_rvalid, wr_valid, wr_ready;
  logic [16:0] vga_addr, wr_addr, mem_addr;
  logic [15:0] vga_data, wr_data, mem_wdata, mem_rdata;
  logic        clear_start, clear_busy, clear_done, mem_en, mem_we;

  int checks   = 0;
  int failures = 0;

  // model state: clear in progress and number of RAM cycles the clear has owned
  bit m_clearing;
  int m_writes;
  bit m_done_exp;
  bit m_rvalid_exp;

  always #5 clk = ~clk;

  frame_buffer_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .vga_req_i(vga_req), .vga_addr_i(vga_addr), .vga_data_o(vga_data),
    .vga_rvalid_o(vga_rvalid),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .clear_start_i(clear_start), .clear_busy_o(clear_busy), .clear_done_o(clear_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  task automatic model_reset();
    m_clearing   = 0;
    m_writes     = 0;
    m_done_exp   = 0;
    m_rvalid_exp = 0;
  endtask

  task automatic model_update();
    m_done_exp = 0;
    if (m_clearing) begin
      if (!vga_req) begin
        m_writes++;
        if (m_writes == FB_PIXELS) begin
          m_clearing = 0;
          m_done_exp = 1;
        end
      end
    end else if (clear_start) begin
      m_clearing = 1;
      m_writes   = 0;
    end
    m_rvalid_exp = vga_req;
  endtask

  // expected RAM-side outputs for the current inputs; wdata is don't-care on VGA reads
  function automatic logic [36:0] expect_outs();
    logic en, we, rdy;
    logic [16:0] a;
    logic [15:0] d;
    en = 0; we = 0; rdy = 0; a = '0; d = '0;
    if (vga_req) begin
      en = 1; a = vga_addr;
    end else if (m_clearing) begin
      en = 1; we = 1; a = 17'(m_writes); d = 16'h0000;
    end else begin
      rdy = 1;
      if (wr_valid) begin
        en = 1; we = (int'(wr_addr) < FB_PIXELS); a = wr_addr; d = wr_data;
      end
    end
    return {en, we, rdy, a, d};
  endfunction

  function automatic logic [36:0] observed_outs();
    return {mem_en, mem_we, wr_ready, mem_addr, vga_req ? 16'h0000 : mem_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vga_req = 0; vga_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    clear_start = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", clear_busy); end
    checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", clear_done); end
    checks++; if (vga_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", vga_rvalid); end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mem got en=%b we=%b addr=%0d wdata=%h exp all zero", mem_en, mem_we, mem_addr, mem_wdata);
    end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_vga_read();
    vga_req = 1; vga_addr = 17'd5; wr_valid = 1; wr_addr = 17'd7; wr_data = 16'h1234;
    #1;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL vga_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (mem_addr !== 17'd5) begin failures++; $display("FAIL vga_addr got=%0d exp=5", mem_addr); end
    checks++;
    if (mem_we !== 1'b0 || mem_en !== 1'b1) begin
      failures++; $display("FAIL vga_en_we got en=%b we=%b exp en=1 we=0", mem_en, mem_we);
    end
    tick();
    vga_req = 0; wr_valid = 0; mem_rdata = 16'hABCD;
    #1;
    checks++; if (vga_rvalid !== 1'b1) begin failures++; $display("FAIL vga_rvalid got=%b exp=1", vga_rvalid); end
    checks++; if (vga_data !== 16'hABCD) begin failures++; $display("FAIL vga_data got=%h exp=abcd", vga_data); end
    tick();
    checks++; if (vga_rvalid !== 1'b0) begin failures++; $display("FAIL vga_rvalid_drop got=%b exp=0", vga_rvalid); end
  endtask

  task automatic test_write();
    vga_req = 0; wr_valid = 1; wr_addr = 17'd100; wr_data = 16'hF800;
    #1;
    checks++;
    if ({mem_en, mem_we, wr_ready, mem_addr, mem_wdata} !== {3'b111, 17'd100, 16'hF800}) begin
      failures++;
      $display("FAIL write_grant got en=%b we=%b rdy=%b addr=%0d wdata=%h exp 1 1 1 100 f800",
               mem_en, mem_we, wr_ready, mem_addr, mem_wdata);
    end
    tick();
    wr_valid = 0;
  endtask

  task automatic test_out_of_range();
    logic [16:0] addrs [3];
    logic        exp_we [3];
    addrs[0] = 17'd76800;  exp_we[0] = 0;
    addrs[1] = 17'd76799;  exp_we[1] = 1;
    addrs[2] = 17'h1FFFF;  exp_we[2] = 0;
    for (int i = 0; i < 3; i++) begin
      vga_req = 0; wr_valid = 1; wr_addr = addrs[i]; wr_data = 16'h5A5A;
      #1;
      checks++;
      if (wr_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== exp_we[i]) begin
        failures++;
        $display("FAIL oor_write addr=%0d got rdy=%b en=%b we=%b exp rdy=1 en=1 we=%b",
                 addrs[i], wr_ready, mem_en, mem_we, exp_we[i]);
      end
      tick();
    end
    wr_valid = 0;
  endtask

  task automatic test_random_traffic();
    logic [36:0] e;
    for (int c = 0; c < 300; c++) begin
      vga_req   = ($urandom_range(0, 2) == 0);
      vga_addr  = 17'($urandom_range(0, FB_PIXELS - 1));
      wr_valid  = $urandom_range(0, 1) == 1;
      wr_addr   = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(FB_PIXELS, 131071))
                                              : 17'($urandom_range(0, FB_PIXELS - 1));
      wr_data   = 16'($urandom);
      mem_rdata = 16'($urandom);
      #1;
      e = expect_outs();
      checks++;
      if (observed_outs() !== e) begin
        failures++;
        $display("FAIL rand_grant cyc=%0d got=%h exp=%h", c, observed_outs(), e);
      end
      checks++;
      if (vga_rvalid !== m_rvalid_exp || vga_data !== mem_rdata) begin
        failures++;
        $display("FAIL rand_read cyc=%0d got rvalid=%b data=%h exp rvalid=%b data=%h",
                 c, vga_rvalid, vga_data, m_rvalid_exp, mem_rdata);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full_clear();
    bit seen [FB_PIXELS];
    int err = 0, dut_writes = 0, dups = 0, order_err = 0, done_pulses = 0;
    // write in the same cycle as clear_start still lands
    vga_req = 0; clear_start = 1; wr_valid = 1; wr_addr = 17'd200; wr_data = 16'h07E0;
    #1;
    checks++;
    if ({mem_en, mem_we, wr_ready, mem_addr, mem_wdata} !== {3'b111, 17'd200, 16'h07E0}) begin
      failures++;
      $display("FAIL clear_start_write got en=%b we=%b rdy=%b addr=%0d exp 1 1 1 200",
               mem_en, mem_we, wr_ready, mem_addr);
    end
    tick();
    clear_start = 0;
    for (int c = 0; c < FB_PIXELS + 10; c++) begin
      wr_valid    = $urandom_range(0, 1) == 1;
      wr_addr     = 17'($urandom_range(0, FB_PIXELS - 1));
      clear_start = (c == 500);
      #1;
      if (observed_outs() !== expect_outs()) err++;
      if (clear_busy !== m_clearing || clear_done !== m_done_exp) err++;
      if (clear_done === 1'b1) done_pulses++;
      if (mem_en && mem_we && !wr_ready) begin
        if (int'(mem_addr) != dut_writes || mem_wdata !== 16'h0000) order_err++;
        if (int'(mem_addr) < FB_PIXELS) begin
          if (seen[mem_addr]) dups++;
          seen[mem_addr] = 1;
        end
        dut_writes++;
      end
      tick();
    end
    idle_inputs();
    checks++; if (err != 0) begin failures++; $display("FAIL clear_model got=%0d mismatching cycles exp=0", err); end
    checks++; if (dut_writes != FB_PIXELS) begin failures++; $display("FAIL clear_count got=%0d exp=%0d", dut_writes, FB_PIXELS); end
    checks++; if (order_err != 0 || dups != 0) begin failures++; $display("FAIL clear_order got order_err=%0d dups=%0d exp 0 0", order_err, dups); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL clear_done_pulses got=%0d exp=1", done_pulses); end
    checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL clear_busy_end got=%b exp=0", clear_busy); end
  endtask

  task automatic test_clear_vga_pause_and_reset();
    bit seen [1000];
    int err = 0, dut_writes = 0, low_cycles = 0, bad = 0, c = 0, done_seen = 0;
    vga_req = 1; clear_start = 1;
    tick();
    clear_start = 0;
    while (dut_writes < 1000 && c < 3000) begin
      vga_req  = (c % 800) < 320;
      vga_addr = 17'($urandom_range(0, FB_PIXELS - 1));
      wr_valid = $urandom_range(0, 1) == 1;
      #1;
      if (observed_outs() !== expect_outs()) err++;
      if (vga_rvalid !== m_rvalid_exp || clear_busy !== 1'b1) err++;
      if (!vga_req) low_cycles++;
      if (mem_we) begin
        if (int'(mem_addr) >= 1000 || seen[mem_addr]) bad++;
        else seen[mem_addr] = 1;
        dut_writes++;
      end
      c++;
      tick();
    end
    checks++; if (c >= 3000) begin failures++; $display("FAIL pause_timeout got writes=%0d exp=1000", dut_writes); end
    checks++; if (err != 0) begin failures++; $display("FAIL pause_model got=%0d mismatching cycles exp=0", err); end
    checks++; if (dut_writes != low_cycles || bad != 0) begin
      failures++; $display("FAIL pause_log got writes=%0d bad=%0d exp writes=%0d bad=0", dut_writes, bad, low_cycles);
    end
    vga_req = 0; wr_valid = 0;
    #1;
    checks++; if (mem_addr !== 17'd1000 || mem_we !== 1'b1) begin
      failures++; $display("FAIL pause_resume_addr got=%0d we=%b exp=1000 we=1", mem_addr, mem_we);
    end
    #1 rst = 1;
    model_reset();
    #1;
    checks++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      failures++; $display("FAIL reset_abort got busy=%b done=%b exp 0 0", clear_busy, clear_done);
    end
    checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL reset_abort_mem got we=%b rdy=%b exp we=0 rdy=1", mem_we, wr_ready);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (clear_done === 1'b1 || clear_busy === 1'b1) done_seen++;
      tick();
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL reset_no_done got=%0d active cycles exp=0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_vga_read();
    test_write();
    test_out_of_range();
    test_random_traffic();
    test_full_clear();
    test_clear_vga_pause_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
